// File: rtl/intc.sv
// Interrupt controller: per-source synchroniser, level/edge + polarity detection,
// enable masking and a single registered interrupt request on the 5-bit CSR bus.
module intc #(
    parameter logic [4:0]  BASE_ADDR   = 5'h0,
    parameter int unsigned NUM_IRQS    = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [15:0] DFL_ENABLE  = 16'h0000,
    parameter logic [15:0] DFL_MODE    = 16'h0000,
    parameter logic [15:0] DFL_POL     = 16'h0000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [4:0]          csr_a,
    input  logic [7:0]          csr_di,
    input  logic                csr_we,
    output logic [7:0]          csr_do,
    input  logic [NUM_IRQS-1:0] irq_in,
    output logic                irq_out
);

    localparam int unsigned NBANKS = (NUM_IRQS <= 8) ? 1 : 2;
    localparam int unsigned NREGS  = 4 * NBANKS;
    localparam logic [15:0] VALID  = 16'((32'd1 << NUM_IRQS) - 32'd1);

    localparam logic [1:0] REG_STATUS = 2'd0;
    localparam logic [1:0] REG_ENABLE = 2'd1;
    localparam logic [1:0] REG_MODE   = 2'd2;
    localparam logic [1:0] REG_POL    = 2'd3;

    logic [NUM_IRQS-1:0] sync_q [SYNC_STAGES];
    logic [15:0] en_q, en_d;
    logic [15:0] mode_q, mode_d;
    logic [15:0] pol_q, pol_d;
    logic [15:0] prev_q;
    logic [15:0] pend_q, pend_d;
    logic        irq_q, irq_d;

    logic [5:0]  off;
    logic        hit;
    logic        bank;
    logic [1:0]  rsel;
    logic [15:0] bmask;
    logic [15:0] wdat;
    logic [15:0] w1c;
    logic [15:0] sy;
    logic [15:0] s;
    logic [15:0] set;
    logic [15:0] rd16;

    // Address decode; the 6-bit difference keeps addresses below BASE_ADDR out of range.
    always_comb begin
        off   = {1'b0, csr_a} - {1'b0, BASE_ADDR};
        hit   = off < 6'(NREGS);
        bank  = off[2];
        rsel  = off[1:0];
        bmask = bank ? 16'hff00 : 16'h00ff;
        wdat  = {csr_di, csr_di} & bmask & VALID;
    end

    // Next-state for configuration, pending bits and the interrupt line.
    always_comb begin
        en_d   = en_q;
        mode_d = mode_q;
        pol_d  = pol_q;
        w1c    = '0;

        sy = 16'(sync_q[SYNC_STAGES-1]);
        s  = sy ^ pol_q;

        if (csr_we && hit) begin
            case (rsel)
                REG_STATUS: w1c    = wdat;
                REG_ENABLE: en_d   = (en_q & ~bmask) | wdat;
                REG_MODE:   mode_d = (mode_q & ~bmask) | wdat;
                REG_POL:    pol_d  = (pol_q & ~bmask) | wdat;
                default:    w1c    = '0;
            endcase
        end

        // Edge sources: set beats a simultaneous W1C. Level sources track s.
        set    = mode_q & s & ~prev_q;
        pend_d = (mode_q & ((pend_q & ~w1c) | set)) | (~mode_q & s);
        irq_d  = |(pend_q & en_q);
    end

    // CSR read mux, combinational and side-effect free.
    always_comb begin
        rd16 = '0;
        case (rsel)
            REG_STATUS: rd16 = pend_q;
            REG_ENABLE: rd16 = en_q;
            REG_MODE:   rd16 = mode_q;
            REG_POL:    rd16 = pol_q;
            default:    rd16 = '0;
        endcase
        csr_do = hit ? (bank ? rd16[15:8] : rd16[7:0]) : 8'h00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= '0;
            end
            en_q   <= DFL_ENABLE & VALID;
            mode_q <= DFL_MODE & VALID;
            pol_q  <= DFL_POL & VALID;
            prev_q <= DFL_POL & VALID;
            pend_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            sync_q[0] <= irq_in;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            en_q   <= en_d;
            mode_q <= mode_d;
            pol_q  <= pol_d;
            prev_q <= s;
            pend_q <= pend_d;
            irq_q  <= irq_d;
        end
    end

    assign irq_out = irq_q;

endmodule

// File: tb/tb_intc.sv
// Directed bench for intc: register table plus level/edge/W1C/mask/reset sequences.
module tb_intc;

    logic        clk;
    logic        rst_n;
    logic [4:0]  csr_a;
    logic [7:0]  csr_di;
    logic        csr_we;
    logic [7:0]  do1, do2, csr_do;
    logic [11:0] irq_in;
    logic [3:0]  irq_in2;
    logic        irq_out, irq2_out;

    int total = 0;
    int bad   = 0;

    intc #(
        .BASE_ADDR(5'h00), .NUM_IRQS(12), .SYNC_STAGES(2),
        .DFL_ENABLE(16'h0000), .DFL_MODE(16'h0000), .DFL_POL(16'h0000)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .csr_a(csr_a), .csr_di(csr_di), .csr_we(csr_we),
        .csr_do(do1), .irq_in(irq_in), .irq_out(irq_out)
    );

    intc #(
        .BASE_ADDR(5'h1c), .NUM_IRQS(4), .SYNC_STAGES(2),
        .DFL_ENABLE(16'h0031), .DFL_MODE(16'h0011), .DFL_POL(16'h0011)
    ) u_dut2 (
        .clk(clk), .rst_n(rst_n), .csr_a(csr_a), .csr_di(csr_di), .csr_we(csr_we),
        .csr_do(do2), .irq_in(irq_in2), .irq_out(irq2_out)
    );

    assign csr_do = do1 | do2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         we;
        logic [4:0] a;
        logic [7:0] d;
        logic [7:0] exp;
    } vec_t;

    localparam int NVEC = 25;
    vec_t tbl [NVEC];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h, want %02h", name, act, exp);
        end
    endtask

    task automatic csr_wr(input logic [4:0] a, input logic [7:0] d);
        csr_a  = a;
        csr_di = d;
        csr_we = 1'b1;
        @(negedge clk);
        csr_we = 1'b0;
    endtask

    task automatic csr_rd(input logic [4:0] a, output logic [7:0] v);
        csr_a = a;
        #1;
        v = csr_do;
    endtask

    logic [7:0] got;

    initial begin
        tbl[0]  = '{0, 5'h00, 8'h00, 8'h00};
        tbl[1]  = '{0, 5'h01, 8'h00, 8'h00};
        tbl[2]  = '{0, 5'h02, 8'h00, 8'h00};
        tbl[3]  = '{0, 5'h03, 8'h00, 8'h00};
        tbl[4]  = '{0, 5'h04, 8'h00, 8'h00};
        tbl[5]  = '{0, 5'h05, 8'h00, 8'h00};
        tbl[6]  = '{0, 5'h06, 8'h00, 8'h00};
        tbl[7]  = '{0, 5'h07, 8'h00, 8'h00};
        tbl[8]  = '{0, 5'h08, 8'h00, 8'h00};
        tbl[9]  = '{0, 5'h10, 8'h00, 8'h00};
        tbl[10] = '{0, 5'h1c, 8'h00, 8'h00};
        tbl[11] = '{0, 5'h1d, 8'h00, 8'h01};
        tbl[12] = '{0, 5'h1e, 8'h00, 8'h01};
        tbl[13] = '{0, 5'h1f, 8'h00, 8'h01};
        tbl[14] = '{1, 5'h01, 8'hff, 8'hff};
        tbl[15] = '{1, 5'h01, 8'h00, 8'h00};
        tbl[16] = '{1, 5'h06, 8'hff, 8'h0f};
        tbl[17] = '{1, 5'h06, 8'h00, 8'h00};
        tbl[18] = '{1, 5'h05, 8'hff, 8'h0f};
        tbl[19] = '{1, 5'h05, 8'h00, 8'h00};
        tbl[20] = '{1, 5'h03, 8'ha5, 8'ha5};
        tbl[21] = '{1, 5'h03, 8'h00, 8'h00};
        tbl[22] = '{1, 5'h08, 8'hff, 8'h00};
        tbl[23] = '{1, 5'h1d, 8'hff, 8'h0f};
        tbl[24] = '{1, 5'h1d, 8'h01, 8'h01};

        rst_n   = 1'b0;
        csr_a   = 5'h00;
        csr_di  = 8'h00;
        csr_we  = 1'b0;
        irq_in  = '0;
        irq_in2 = 4'b0001;

        // Reset held: irq_out must stay low.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("irq_in_reset", {7'd0, irq_out}, 8'h00);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Register table: reset values, truncation, unmapped addresses.
        for (int i = 0; i < NVEC; i++) begin
            if (tbl[i].we) csr_wr(tbl[i].a, tbl[i].d);
            csr_rd(tbl[i].a, got);
            chk($sformatf("tbl[%0d] a=%02h", i, tbl[i].a), got, tbl[i].exp);
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        csr_rd(5'h00, got);
        chk("status0_after_pol_restore", got, 8'h00);
        chk("irq_idle", {7'd0, irq_out}, 8'h00);
        chk("irq2_idle", {7'd0, irq2_out}, 8'h00);
        @(negedge clk);

        // Level source 3.
        csr_wr(5'h01, 8'h08);
        irq_in[3] = 1'b1;
        repeat (3) @(negedge clk);
        chk("lvl_rise_early", {7'd0, irq_out}, 8'h00);
        @(negedge clk);
        chk("lvl_rise", {7'd0, irq_out}, 8'h01);
        csr_wr(5'h00, 8'h08);
        csr_rd(5'h00, got);
        chk("lvl_w1c_ignored", got, 8'h08);
        chk("lvl_w1c_irq", {7'd0, irq_out}, 8'h01);
        @(negedge clk);
        irq_in[3] = 1'b0;
        repeat (3) @(negedge clk);
        chk("lvl_fall_early", {7'd0, irq_out}, 8'h01);
        @(negedge clk);
        chk("lvl_fall", {7'd0, irq_out}, 8'h00);
        csr_wr(5'h01, 8'h00);

        // Edge falling source 9 (bank 1 bit 1).
        irq_in[9] = 1'b1;
        repeat (3) @(negedge clk);
        csr_wr(5'h05, 8'h02);
        csr_wr(5'h07, 8'h02);
        repeat (2) @(negedge clk);
        csr_wr(5'h04, 8'h02);
        csr_rd(5'h04, got);
        chk("edge_status_cleared", got, 8'h00);
        @(negedge clk);
        csr_wr(5'h06, 8'h02);
        repeat (2) @(negedge clk);
        chk("edge_idle_irq", {7'd0, irq_out}, 8'h00);
        irq_in[9] = 1'b0;
        repeat (3) @(negedge clk);
        chk("edge_fall_early", {7'd0, irq_out}, 8'h00);
        @(negedge clk);
        chk("edge_fall_irq", {7'd0, irq_out}, 8'h01);
        csr_rd(5'h04, got);
        chk("edge_status1", got, 8'h02);
        @(negedge clk);
        irq_in[9] = 1'b1;
        repeat (4) @(negedge clk);
        csr_rd(5'h04, got);
        chk("edge_held", got, 8'h02);
        @(negedge clk);
        csr_wr(5'h04, 8'h02);
        chk("edge_w1c_same", {7'd0, irq_out}, 8'h01);
        @(negedge clk);
        chk("edge_w1c_next", {7'd0, irq_out}, 8'h00);
        csr_wr(5'h06, 8'h00);

        // Simultaneous set and W1C on edge source 0.
        csr_wr(5'h02, 8'h01);
        csr_wr(5'h01, 8'h01);
        irq_in[0] = 1'b1;
        repeat (4) @(negedge clk);
        chk("sim_first_irq", {7'd0, irq_out}, 8'h01);
        irq_in[0] = 1'b0;
        repeat (3) @(negedge clk);
        csr_rd(5'h00, got);
        chk("sim_hold", got, 8'h01);
        @(negedge clk);
        irq_in[0] = 1'b1;
        repeat (2) @(negedge clk);
        csr_wr(5'h00, 8'h01);
        csr_rd(5'h00, got);
        chk("sim_set_wins", got, 8'h01);
        chk("sim_irq", {7'd0, irq_out}, 8'h01);
        @(negedge clk);
        chk("sim_irq_next", {7'd0, irq_out}, 8'h01);
        csr_wr(5'h00, 8'h01);
        csr_rd(5'h00, got);
        chk("sim_clear", got, 8'h00);
        @(negedge clk);
        chk("sim_clear_irq", {7'd0, irq_out}, 8'h00);

        // Masking.
        irq_in[0] = 1'b0;
        repeat (3) @(negedge clk);
        csr_wr(5'h01, 8'h00);
        irq_in[0] = 1'b1;
        repeat (4) @(negedge clk);
        csr_rd(5'h00, got);
        chk("mask_pending", got, 8'h01);
        chk("mask_irq", {7'd0, irq_out}, 8'h00);
        @(negedge clk);
        csr_wr(5'h01, 8'h01);
        chk("unmask_same", {7'd0, irq_out}, 8'h00);
        @(negedge clk);
        chk("unmask_next", {7'd0, irq_out}, 8'h01);

        // Asynchronous reset while pending.
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_irq", {7'd0, irq_out}, 8'h00);
        csr_rd(5'h00, got);
        chk("async_rst_status", got, 8'h00);
        csr_rd(5'h02, got);
        chk("async_rst_mode", got, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Active-low idle-high source on dut2: no spurious pending after reset.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("no_spurious_irq2 c%0d", i), {7'd0, irq2_out}, 8'h00);
        end
        csr_rd(5'h1c, got);
        chk("no_spurious_status2", got, 8'h00);
        chk("post_rst_irq1", {7'd0, irq_out}, 8'h00);
        @(negedge clk);
        irq_in2[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("dut2_fall_early", {7'd0, irq2_out}, 8'h00);
        @(negedge clk);
        chk("dut2_fall_irq", {7'd0, irq2_out}, 8'h01);
        csr_rd(5'h1c, got);
        chk("dut2_status", got, 8'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
